// File: rtl/data_memory_unit_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_unit_pkg
// Shared definitions for the MEM-stage data memory and its dump engine.
//   DEFAULT_DEPTH_WORDS : default number of 32-bit words in the memory
//   dump_state_t        : state encoding of the dump streamer FSM
// -----------------------------------------------------------------------------
package data_memory_unit_pkg;

    localparam int DEFAULT_DEPTH_WORDS = 512;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_RUN  = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/data_memory_unit_dump_streamer.sv
// -----------------------------------------------------------------------------
// dump_streamer
// Walks the word index 0..DEPTH_WORDS-1 once per start request and presents
// each index on a valid/ready handshake. The owner of the memory array turns
// rd_idx into data, so this block never touches storage itself.
//   clk    in   clock, rising edge
//   srst   in   synchronous active-high reset
//   start  in   begin (or restart from DONE) a full pass; ignored mid-pass
//   ready  in   consumer accepts the presented word
//   valid  out  rd_idx is being presented
//   done   out  full pass has completed
//   rd_idx out  index of the word being presented
// -----------------------------------------------------------------------------
module dump_streamer
    import data_memory_unit_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          start,
    input  logic          ready,
    output logic          valid,
    output logic          done,
    output logic [AW-1:0] rd_idx
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

    dump_state_t   state_reg, state_next;
    logic [AW-1:0] idx_reg, idx_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= DUMP_IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        valid      = 1'b0;
        done       = 1'b0;
        case (state_reg)
            DUMP_IDLE: begin
                if (start) begin
                    state_next = DUMP_RUN;
                    idx_next   = '0;
                end
            end
            DUMP_RUN: begin
                valid = 1'b1;
                if (ready) begin
                    // Index stays on the last word when leaving; it is
                    // reloaded with 0 on the next start.
                    if (idx_reg == LAST_IDX) begin
                        state_next = DUMP_DONE;
                    end else begin
                        idx_next = idx_reg + AW'(1);
                    end
                end
            end
            DUMP_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = DUMP_RUN;
                    idx_next   = '0;
                end
            end
            default: begin
                state_next = DUMP_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    assign rd_idx = idx_reg;

endmodule

// File: rtl/data_memory_unit.sv
// -----------------------------------------------------------------------------
// data_memory_unit
// Word-addressed data memory for the MEM stage of the pipelined CPU, with a
// dump engine that streams the whole image out after the program halts.
//   CLOCK          in   clock, rising edge
//   RESET          in   synchronous active-high reset (also clears memory)
//   MemWriteEN_M   in   store enable
//   Mem2RegSEL_M   in   load indicator (only used for error reporting)
//   ALUOut_M       in   byte address
//   MemWriteData_M in   store data
//   MemReadData_M  out  combinational load data (0 when out of range)
//   AccessErr      out  sticky out-of-range / misaligned access flag
//   Dump_Start     in   start a full-memory dump
//   Dump_Valid     out  Dump_Index / Dump_Data valid
//   Dump_Ready     in   consumer accepts the current word
//   Dump_Index     out  word index presented
//   Dump_Data      out  word contents presented
//   Dump_Done      out  full image transferred
// -----------------------------------------------------------------------------
module data_memory_unit
    import data_memory_unit_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          MemWriteEN_M,
    input  logic          Mem2RegSEL_M,
    input  logic [31:0]   ALUOut_M,
    input  logic [31:0]   MemWriteData_M,
    output logic [31:0]   MemReadData_M,
    output logic          AccessErr,
    input  logic          Dump_Start,
    output logic          Dump_Valid,
    input  logic          Dump_Ready,
    output logic [AW-1:0] Dump_Index,
    output logic [31:0]   Dump_Data,
    output logic          Dump_Done
);

    // The array must clear on reset and be read combinationally on two
    // ports, so it is built from registers rather than block RAM.
    logic [31:0]   mem_reg [DEPTH_WORDS];

    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          misaligned;
    logic          access_err_reg;
    logic [AW-1:0] dump_idx;
    logic          dump_valid;

    assign word_idx   = ALUOut_M[AW+1:2];
    assign in_range   = (ALUOut_M[31:AW+2] == '0);
    assign misaligned = (ALUOut_M[1:0] != 2'b00);

    // Store path: out-of-range stores are dropped; misaligned stores hit
    // the aligned word.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (MemWriteEN_M && in_range) begin
            mem_reg[word_idx] <= MemWriteData_M;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            access_err_reg <= 1'b0;
        end else if ((MemWriteEN_M || Mem2RegSEL_M) && (!in_range || misaligned)) begin
            access_err_reg <= 1'b1;
        end
    end

    assign MemReadData_M = in_range ? mem_reg[word_idx] : 32'h0;
    assign AccessErr     = access_err_reg;

    dump_streamer #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_dump_streamer (
        .clk    (CLOCK),
        .srst   (RESET),
        .start  (Dump_Start),
        .ready  (Dump_Ready),
        .valid  (dump_valid),
        .done   (Dump_Done),
        .rd_idx (dump_idx)
    );

    // Read is combinational from the current array, so a store landing on
    // the word being accepted is not seen by that beat.
    assign Dump_Valid = dump_valid;
    assign Dump_Index = dump_idx;
    assign Dump_Data  = dump_valid ? mem_reg[dump_idx] : 32'h0;

endmodule

// File: doc/data_memory_unit.md
# data_memory_unit

Data-memory responder for the pipelined CPU's MEM stage. It serves word loads and stores issued by the EX/MEM pipeline register, and it includes a sequential dump engine. The testbench uses the dump engine to stream the full memory image out through a valid/ready handshake once the program has halted. Loads are combinational, so the MEM/WB register can capture read data in the same cycle; stores commit on the clock edge.

## Interface
Parameters:
- DEPTH_WORDS, 512, number of 32-bit words; power of two, minimum 4.
- AW, log2(DEPTH_WORDS) = 9, word-index width.

Ports:
- CLOCK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  reset; synchronous and active-high.
- MemWriteEN_M  in  1  store enable from the MEM stage.
- Mem2RegSEL_M  in  1  load indicator; only qualifies error reporting.
- ALUOut_M  in  32  byte address.
- MemWriteData_M  in  32  store data.
- MemReadData_M  out  32  load data (combinational).
- AccessErr  out  1  sticky flag for an out-of-range or misaligned access.
- Dump_Start  in  1  request to stream the whole memory.
- Dump_Valid  out  1  Dump_Data and Dump_Index are valid.
- Dump_Ready  in  1  consumer accepts the current word.
- Dump_Index  out  AW  word index being presented.
- Dump_Data  out  32  word contents.
- Dump_Done  out  1  full image has been transferred.

## Operation
- Word index = ALUOut_M[AW+1:2].
- An address is in range when ALUOut_M[31:AW+2] == 0.
- Misaligned means ALUOut_M[1:0] != 0. The low bits are ignored and the aligned word is accessed.
- Load: MemReadData_M = mem[index] when in range; otherwise 0.
- Store: when MemWriteEN_M is high and the address is in range, mem[index] <= MemWriteData_M at the edge. Out-of-range stores are dropped.
- AccessErr sets on any edge where (MemWriteEN_M or Mem2RegSEL_M) is high and the address is out of range or misaligned. It stays set until RESET.
- Dump FSM states are IDLE, DUMP, and DONE:
  - IDLE: Dump_Valid=0. Dump_Start=1 moves to DUMP with idx <= 0.
  - DUMP: Dump_Valid=1, Dump_Index=idx, Dump_Data=mem[idx] (combinational). On Dump_Valid&&Dump_Ready: if idx==DEPTH_WORDS-1, go to DONE; else idx <= idx+1. If Ready is low, hold idx, and Valid stays high.
  - DUMP: Dump_Start is ignored.
  - DONE: Dump_Done=1 and Dump_Valid=0. Dump_Start=1 restarts the dump (DUMP, idx <= 0).
- Stores remain serviced in every FSM state.
- Store to idx while that word is being accepted: the transferred word is the pre-store value. The new value is visible on the next cycle.
- Stores to indices already transferred are not re-sent.

## Timing
- Reset actions:
  - FSM goes to IDLE and idx to 0.
  - All memory words are cleared to 0.
  - AccessErr=0.
  - Dump_Valid=0, Dump_Done=0, Dump_Index=0, Dump_Data=0.
  - MemReadData_M=0, because memory is zero.
- RESET takes priority over stores and FSM transitions in the same cycle.
- RESET mid-dump aborts the transfer: Valid drops on the next cycle.
- Load latency is 0 cycles (combinational). A store is visible to a load 1 cycle later.
- Dump_Valid is high from the cycle after Start is sampled.
- With Ready held high, the dump takes exactly DEPTH_WORDS cycles. Dump_Done rises on the cycle after the last handshake.

## Structure
- A shared package or header holds:
  - the FSM state encoding: DUMP_IDLE=2'd0, DUMP_RUN=2'd1, DUMP_DONE=2'd2;
  - the default depth constant.
- Sub-module dump_streamer contains the FSM, idx counter, and handshake. It exposes a read-index port into the memory array.
- The storage array and store/load logic stay in data_memory_unit.

## Test plan
- Store, then load:
  - Store 0xDEADBEEF at address 0x10, then load 0x10 on the next cycle: MemReadData_M=0xDEADBEEF and AccessErr=0.
  - Load address 0x14 in the same program: returns 0.
- Out-of-range store: store at address 0x800 (index 512 with DEPTH_WORDS=512). Memory is unchanged, AccessErr=1 from the next cycle, and a load of 0x800 returns 0.
- Misaligned store: store 0x12345678 at 0x21. Word 8 becomes 0x12345678 and AccessErr=1.
- Full dump with Ready=1:
  - Preload word i = i*3. Pulse Dump_Start.
  - Expect 512 consecutive beats with Index 0..511 and Data i*3.
  - Dump_Done=1 on cycle 513 after Start; Valid=0 afterwards.
- Backpressure:
  - Hold Ready=0 for 5 cycles at idx=7: Index stays 7 and Valid stays 1.
  - Store 0xAAAA to word 7 in the handshake cycle: the beat carries the old value, and word 7 then reads 0xAAAA.
- Reset mid-dump at idx=100:
  - Next cycle: Valid=0, Done=0, and all words read 0.
  - A new Dump_Start begins again at Index 0.
